// File: rtl/prod_accum.sv
// Frame accumulator for multiplier products: sums a valid/ready product stream with
// saturation and offers total, term count and overflow flag on an output handshake.
module prod_accum #(
    parameter int unsigned PROD_W    = 8,
    parameter int unsigned ACC_W     = 12,
    parameter int unsigned MAX_TERMS = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [PROD_W-1:0]                  in_prod,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_W-1:0]                   out_sum,
    output logic [$clog2(MAX_TERMS+1)-1:0]     out_count,
    output logic                               out_ovf
);

    localparam int unsigned CNT_W      = $clog2(MAX_TERMS + 1);
    localparam int unsigned SUM_W      = ACC_W + 1;
    localparam bit          SINGLE     = (MAX_TERMS == 1);
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q;

    logic               in_acc;
    logic               out_acc;
    logic [SUM_W-1:0]   sum_ext;
    logic [CNT_W-1:0]   cnt_inc;

    // Ready depends only on state (and reset), never on in_valid.
    assign in_ready = rst_n & (state_q != DONE);
    assign in_acc   = in_valid & in_ready;
    assign out_acc  = out_valid_q & out_ready;

    // One extra bit catches the carry that triggers saturation.
    assign sum_ext  = {1'b0, acc_q} + SUM_W'(in_prod);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_acc) begin
                    acc_d   = ACC_W'(in_prod);
                    cnt_d   = CNT_W'(1);
                    ovf_d   = 1'b0;
                    state_d = (in_last || SINGLE) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_acc) begin
                    if (sum_ext[ACC_W]) begin
                        acc_d = ACC_MAX;
                        ovf_d = 1'b1;
                    end else begin
                        acc_d = sum_ext[ACC_W-1:0];
                    end
                    cnt_d = cnt_inc;
                    if (in_last || (cnt_inc == CNT_MAX)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= (state_d == DONE);
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a default instance (ACC_W=12) and a narrow
// instance (ACC_W=10) share stimulus; the narrow one exercises saturation.
module tb_prod_accum;

    localparam int unsigned PROD_W    = 8;
    localparam int unsigned MAX_TERMS = 16;
    localparam int unsigned CNT_W     = $clog2(MAX_TERMS + 1);
    localparam int          TMO       = 50;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [PROD_W-1:0]  in_prod;
    logic               in_last;
    logic               out_ready;

    logic               a_in_ready, a_out_valid, a_out_ovf;
    logic [11:0]        a_out_sum;
    logic [CNT_W-1:0]   a_out_count;
    logic               b_in_ready, b_out_valid, b_out_ovf;
    logic [9:0]         b_out_sum;
    logic [CNT_W-1:0]   b_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prod_accum #(.PROD_W(PROD_W), .ACC_W(12), .MAX_TERMS(MAX_TERMS)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    prod_accum #(.PROD_W(PROD_W), .ACC_W(10), .MAX_TERMS(MAX_TERMS)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_sum(b_out_sum), .out_count(b_out_count), .out_ovf(b_out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one product and hold it until accepted by instance A.
    task automatic send(input logic [PROD_W-1:0] p, input logic last);
        int n;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        n = 0;
        while (!a_in_ready && n < TMO) begin
            step();
            n++;
        end
        if (n >= TMO) check("send_timeout", 32'(n), 32'(0));
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!a_out_valid && n < TMO) begin
            step();
            n++;
        end
        if (n >= TMO) check("out_timeout", 32'(n), 32'(0));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        step();
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready",  32'(a_in_ready),  32'd0);
        check("rst_sum",       32'(a_out_sum),   32'd0);
        check("rst_count",     32'(a_out_count), 32'd0);
        check("rst_ovf",       32'(a_out_ovf),   32'd0);
        rst_n = 1'b1;
        step();
        check("idle_in_ready", 32'(a_in_ready),  32'd1);

        // Reset mid-frame discards the partial sum
        send(8'd100, 1'b0);
        send(8'd50,  1'b0);
        send(8'd20,  1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_in_ready",  32'(a_in_ready),  32'd0);
        step();
        check("midrst_out_valid2", 32'(a_out_valid), 32'd0);
        rst_n = 1'b1;
        step();
        send(8'd5, 1'b1);
        check("t1_valid", 32'(a_out_valid), 32'd1);
        check("t1_sum",   32'(a_out_sum),   32'd5);
        check("t1_count", 32'(a_out_count), 32'd1);
        check("t1_ovf",   32'(a_out_ovf),   32'd0);
        consume();

        // Basic frame with out_ready held high
        out_ready = 1'b1;
        send(8'd15,  1'b0);
        send(8'd225, 1'b0);
        send(8'd6,   1'b1);
        check("t2_valid", 32'(a_out_valid), 32'd1);
        check("t2_sum",   32'(a_out_sum),   32'd246);
        check("t2_count", 32'(a_out_count), 32'd3);
        check("t2_ovf",   32'(a_out_ovf),   32'd0);
        step();
        check("t2_valid_one_cycle", 32'(a_out_valid), 32'd0);
        out_ready = 1'b0;

        // Auto-close after MAX_TERMS products
        for (int i = 0; i < 15; i++) begin
            send(8'd225, 1'b0);
            check("t3_no_early_close", 32'(a_out_valid), 32'd0);
        end
        send(8'd225, 1'b0);
        check("t3_in_ready", 32'(a_in_ready),  32'd0);
        check("t3_valid",    32'(a_out_valid), 32'd1);
        check("t3_sum",      32'(a_out_sum),   32'd3600);
        check("t3_count",    32'(a_out_count), 32'd16);
        check("t3_ovf",      32'(a_out_ovf),   32'd0);
        check("t3_b_sum",    32'(b_out_sum),   32'd1023);
        check("t3_b_ovf",    32'(b_out_ovf),   32'd1);
        consume();

        // Saturation on the narrow instance; wide one does not saturate
        for (int i = 0; i < 4; i++) send(8'd255, 1'b0);
        send(8'd255, 1'b1);
        check("t4_b_valid", 32'(b_out_valid), 32'd1);
        check("t4_b_sum",   32'(b_out_sum),   32'd1023);
        check("t4_b_ovf",   32'(b_out_ovf),   32'd1);
        check("t4_b_count", 32'(b_out_count), 32'd5);
        check("t4_a_sum",   32'(a_out_sum),   32'd1275);
        check("t4_a_ovf",   32'(a_out_ovf),   32'd0);
        consume();

        // Backpressure: next product waits until after the out accept
        send(8'd7, 1'b1);
        in_valid = 1'b1;
        in_prod  = 8'd9;
        in_last  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_hold_valid", 32'(a_out_valid), 32'd1);
            check("t5_hold_ready", 32'(a_in_ready),  32'd0);
            check("t5_hold_sum",   32'(a_out_sum),   32'd7);
            check("t5_hold_count", 32'(a_out_count), 32'd1);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t5_after_acc_valid", 32'(a_out_valid), 32'd0);
        check("t5_after_acc_ready", 32'(a_in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("t5_next_valid", 32'(a_out_valid), 32'd1);
        check("t5_next_sum",   32'(a_out_sum),   32'd9);
        check("t5_next_count", 32'(a_out_count), 32'd1);
        consume();

        // Bubbles between products keep the frame open
        send(8'd10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("t6_gap_valid", 32'(a_out_valid), 32'd0);
            check("t6_gap_ready", 32'(a_in_ready),  32'd1);
            step();
        end
        send(8'd20, 1'b1);
        wait_out();
        check("t6_sum",   32'(a_out_sum),   32'd30);
        check("t6_count", 32'(a_out_count), 32'd2);
        consume();

        // in_last on the MAX_TERMS-th beat closes the frame once
        for (int i = 0; i < 15; i++) send(8'd1, 1'b0);
        send(8'd1, 1'b1);
        check("t7_sum",   32'(a_out_sum),   32'd16);
        check("t7_count", 32'(a_out_count), 32'd16);
        consume();
        step();
        check("t7_single_close", 32'(a_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
